// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use stall, branch flush, memory freeze and EX operand forwarding control
module hazard_forward_ctrl #(
    parameter int REG_BITS  = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 id_valid,
    input  logic [REG_BITS-1:0]  id_rs,
    input  logic [REG_BITS-1:0]  id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic [REG_BITS-1:0]  id_dst,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 branch_taken,
    input  logic                 mem_busy,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic [CNT_WIDTH-1:0] stall_cnt
);
    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] dst;
        logic                reg_write;
        logic                mem_read;
    } rec_t;

    rec_t                 ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [REG_BITS-1:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic                 ex_uses_rs_q, ex_uses_rs_d, ex_uses_rt_q, ex_uses_rt_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 load_use, flush, stall;

    function automatic logic writes(input rec_t r, input logic [REG_BITS-1:0] src);
        return r.valid & r.reg_write & (|r.dst) & (r.dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src, input logic uses,
                                           input logic ex_v, input rec_t m, input rec_t w);
        return !(ex_v & uses) ? 2'd0 : writes(m, src) ? 2'd2 : writes(w, src) ? 2'd1 : 2'd0;
    endfunction

    assign load_use = ex_q.valid & ex_q.mem_read & (|ex_q.dst) & id_valid &
                      ((id_uses_rs & (id_rs == ex_q.dst)) | (id_uses_rt & (id_rt == ex_q.dst)));
    assign flush = !mem_busy & branch_taken;
    assign stall = !mem_busy & !branch_taken & load_use;

    assign pc_write     = !RESET & !mem_busy & !stall;
    assign if_id_write  = !RESET & !mem_busy & !stall;
    assign if_id_flush  = RESET | flush;
    assign id_ex_bubble = RESET | flush | stall;
    assign fwd_a_sel    = RESET ? 2'd0 : fwd_sel(ex_rs_q, ex_uses_rs_q, ex_q.valid, mem_q, wb_q);
    assign fwd_b_sel    = RESET ? 2'd0 : fwd_sel(ex_rt_q, ex_uses_rt_q, ex_q.valid, mem_q, wb_q);
    assign stall_cnt    = cnt_q;

    always_comb begin
        ex_d         = ex_q;
        mem_d        = mem_q;
        wb_d         = wb_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_uses_rs_d = ex_uses_rs_q;
        ex_uses_rt_d = ex_uses_rt_q;
        cnt_d        = cnt_q;
        if (!mem_busy) begin
            wb_d         = mem_q;
            mem_d        = ex_q;
            ex_d         = '{valid: id_valid & !(flush | stall), dst: id_dst,
                             reg_write: id_reg_write, mem_read: id_mem_read};
            ex_rs_d      = id_rs;
            ex_rt_d      = id_rt;
            ex_uses_rs_d = id_uses_rs;
            ex_uses_rt_d = id_uses_rt;
            cnt_d        = (stall & ~&cnt_q) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_uses_rs_q <= 1'b0;
            ex_uses_rt_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_uses_rs_q <= ex_uses_rs_d;
            ex_uses_rt_q <= ex_uses_rt_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed-vector self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        branch_taken, mem_busy;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt;
    int          n_tot = 0;
    int          n_bad = 0;

    hazard_forward_ctrl dut (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic pc, input logic ifw, input logic fl, input logic bub);
        chk({tag, ".pc_write"}, pc_write, pc);
        chk({tag, ".if_id_write"}, if_id_write, ifw);
        chk({tag, ".if_id_flush"}, if_id_flush, fl);
        chk({tag, ".id_ex_bubble"}, id_ex_bubble, bub);
    endtask

    task automatic fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, ".fwd_a"}, fwd_a_sel, a);
        chk({tag, ".fwd_b"}, fwd_b_sel, b);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] dst, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dst = dst; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; branch_taken = 1'b0; mem_busy = 1'b0;
        nop();
        for (int i = 0; i < 2; i++) begin
            sample();
            ctl("rst", 0, 0, 1, 1);
            fwd("rst", 0, 0);
            tick();
        end
        RESET = 1'b0;
        sample();
        ctl("post_rst", 1, 1, 0, 0);
        fwd("post_rst", 0, 0);
        chk("post_rst.cnt", stall_cnt, 0);
        tick();
        // add r3,r1,r2 ; sub r5,r3,r4 ; and r7,r3,r9
        set_id(1, 1, 2, 1, 1, 3, 1, 0); sample(); tick();
        set_id(1, 3, 4, 1, 1, 5, 1, 0); sample(); tick();
        set_id(1, 3, 9, 1, 1, 7, 1, 0); sample();
        fwd("exmem", 2, 0);
        tick();
        nop(); sample();
        fwd("memwb", 1, 0);
        tick();
        // add r3 twice, then sub r4,r1,r3
        set_id(1, 1, 2, 1, 1, 3, 1, 0); sample(); tick();
        set_id(1, 1, 2, 1, 1, 3, 1, 0); sample(); tick();
        set_id(1, 1, 3, 1, 1, 4, 1, 0); sample();
        fwd("pre_dbl", 0, 0);
        tick();
        nop(); sample();
        fwd("dbl", 0, 2);
        tick();
        // lw r2,0(r1) ; add r6,r2,r2
        set_id(1, 1, 0, 1, 0, 2, 1, 1); sample();
        ctl("lw_issue", 1, 1, 0, 0);
        tick();
        set_id(1, 2, 2, 1, 1, 6, 1, 0); sample();
        ctl("lu_stall", 0, 0, 0, 1);
        chk("lu_stall.cnt", stall_cnt, 0);
        tick();
        sample();
        ctl("lu_resume", 1, 1, 0, 0);
        chk("lu_resume.cnt", stall_cnt, 1);
        tick();
        nop(); sample();
        fwd("lu_fwd", 1, 1);
        tick();
        // lw r0 ; add r5,r0,r0
        set_id(1, 1, 0, 1, 0, 0, 1, 1); sample(); tick();
        set_id(1, 0, 0, 1, 1, 5, 1, 0); sample();
        ctl("r0_lu", 1, 1, 0, 0);
        chk("r0_lu.cnt", stall_cnt, 1);
        tick();
        nop(); sample();
        fwd("r0_fwd", 0, 0);
        tick();
        // lw r4,0(r5) ; add r7,r4,r1 under mem_busy then branch
        set_id(1, 5, 0, 1, 0, 4, 1, 1); sample(); tick();
        set_id(1, 4, 1, 1, 1, 7, 1, 0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            ctl("freeze", 0, 0, 0, 0);
            chk("freeze.cnt", stall_cnt, 1);
            fwd("freeze", 1, 0);
            tick();
        end
        mem_busy = 1'b0; branch_taken = 1'b1;
        sample();
        ctl("branch", 1, 1, 1, 1);
        chk("branch.cnt", stall_cnt, 1);
        fwd("branch", 1, 0);
        tick();
        branch_taken = 1'b0; nop(); sample();
        ctl("after_br", 1, 1, 0, 0);
        chk("after_br.cnt", stall_cnt, 1);
        fwd("after_br", 0, 0);
        tick();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
